// File: rtl/sq_commit_sched_pkg.sv
// ============================================================================
// Module      : sq_commit_sched_pkg
// Description : Shared types for the committed-store write buffer scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef LSQ
`define LSQ
`endif

package sq_commit_sched_pkg;

    localparam int c_NUM_LANES = 3;

    typedef struct packed {
        logic        ready;
        logic [31:0] addr;
        logic [3:0]  usebytes;
        logic [31:0] data;
    } SQ_ENTRY_PACKET;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  usebytes;
    } WB_ENTRY;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2
    } dc_cmd_e;

    function automatic WB_ENTRY to_wb_entry(input SQ_ENTRY_PACKET s);
        WB_ENTRY w;
        w.addr     = s.addr;
        w.data     = s.data;
        w.usebytes = s.usebytes;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sq_commit_sched_wb_fifo.sv
// ============================================================================
// Module      : sq_commit_sched_wb_fifo
// Description : 3-in/1-out circular buffer of committed stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sq_commit_sched_wb_fifo
    import sq_commit_sched_pkg::*;
#(
    parameter int WB_DEPTH = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [1:0]                 i_enq_cnt,
    input  WB_ENTRY [2:0]              i_enq_data,
    input  logic                       i_deq,
    output logic [$clog2(WB_DEPTH):0]  o_count,
    output WB_ENTRY                    o_head
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    WB_ENTRY         r_mem [WB_DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PW'(i_enq_cnt);
            if (i_deq)
                r_head <= r_head + PW'(1);
            r_count <= r_count + CW'(i_enq_cnt) - CW'(i_deq);
        end
    end

    // Lane i lands at tail+i; pointer arithmetic wraps naturally at PW bits.
    always_ff @(posedge i_clock) begin
        for (int i = 0; i < c_NUM_LANES; i++) begin
            if (i_reset && (2'(i) < i_enq_cnt))
                r_mem[r_tail + PW'(i)] <= i_enq_data[i];
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_head];

endmodule

`default_nettype wire

// File: rtl/sq_commit_sched.sv
// ============================================================================
// Module      : sq_commit_sched
// Description : Commits retiring stores into a write buffer and arbitrates the
//               single D-cache port between loads and buffered stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sq_commit_sched
    import sq_commit_sched_pkg::*;
#(
    parameter int WB_DEPTH     = 4,
    parameter int DRAIN_THRESH = 3,
    parameter int STARVE_MAX   = 7
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [2:0]                 i_rob_st_retire,
    input  SQ_ENTRY_PACKET [2:0]       i_sq_head_entries,
    output logic [2:0]                 o_retire,
    output logic [2:0]                 o_retire_stall,
    input  logic                       i_ld_req,
    input  logic [31:0]                i_ld_addr,
    output logic                       o_ld_gnt,
    output logic                       o_dc_valid,
    output logic                       o_dc_wr,
    output logic [31:0]                o_dc_addr,
    output logic [31:0]                o_dc_data,
    output logic [3:0]                 o_dc_usebytes,
    input  logic                       i_dc_ready,
    output logic [$clog2(WB_DEPTH):0]  o_wb_count,
    output logic                       o_wb_empty
);

    localparam int CW = $clog2(WB_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] c_DRAIN_THRESH = CW'(DRAIN_THRESH);
    localparam logic [SW-1:0] c_STARVE_MAX   = SW'(STARVE_MAX);
    localparam logic [CW:0]   c_DEPTH        = (CW+1)'(WB_DEPTH);

    logic [CW-1:0]  w_count;
    WB_ENTRY        w_head;
    WB_ENTRY [2:0]  w_enq_data;
    logic [SW-1:0]  r_starve;
    dc_cmd_e        w_cmd;
    logic           w_store_pri;
    logic           w_deq;
    logic [CW:0]    w_free;
    logic [1:0]     w_avail;
    logic [1:0]     w_k;

    always_comb begin
        w_store_pri = (w_count >= c_DRAIN_THRESH) | (r_starve == c_STARVE_MAX) | ~i_ld_req;
        w_cmd       = CMD_IDLE;
        if (!i_reset)
            w_cmd = CMD_IDLE;
        else if ((w_count != '0) && w_store_pri)
            w_cmd = CMD_STORE;
        else if (i_ld_req)
            w_cmd = CMD_LOAD;
    end

    assign w_deq = (w_cmd == CMD_STORE) & i_dc_ready;

    always_comb begin
        o_dc_valid    = (w_cmd != CMD_IDLE);
        o_dc_wr       = (w_cmd == CMD_STORE);
        o_ld_gnt      = (w_cmd == CMD_LOAD) & i_dc_ready;
        o_dc_addr     = '0;
        o_dc_data     = '0;
        o_dc_usebytes = '0;
        if (w_cmd == CMD_STORE) begin
            o_dc_addr     = w_head.addr;
            o_dc_data     = w_head.data;
            o_dc_usebytes = w_head.usebytes;
        end else if (w_cmd == CMD_LOAD) begin
            o_dc_addr     = i_ld_addr;
        end
    end

    // A slot freed by this cycle's dequeue is reusable by this cycle's enqueue.
    assign w_free = c_DEPTH - {1'b0, w_count} + {{CW{1'b0}}, w_deq};

    always_comb begin
        w_avail = 2'd0;
        if (i_rob_st_retire[0] && i_sq_head_entries[0].ready) begin
            w_avail = 2'd1;
            if (i_rob_st_retire[1] && i_sq_head_entries[1].ready) begin
                w_avail = 2'd2;
                if (i_rob_st_retire[2] && i_sq_head_entries[2].ready)
                    w_avail = 2'd3;
            end
        end
        w_k = 2'd0;
        if (i_reset)
            w_k = ({{(CW-1){1'b0}}, w_avail} > w_free) ? w_free[1:0] : w_avail;
    end

    always_comb begin
        o_retire = 3'b000;
        case (w_k)
            2'd1:    o_retire = 3'b001;
            2'd2:    o_retire = 3'b011;
            2'd3:    o_retire = 3'b111;
            default: o_retire = 3'b000;
        endcase
        o_retire_stall = i_rob_st_retire & ~o_retire;
        for (int i = 0; i < c_NUM_LANES; i++)
            w_enq_data[i] = to_wb_entry(i_sq_head_entries[i]);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset)
            r_starve <= '0;
        else if (w_deq)
            r_starve <= '0;
        else if ((w_count != '0) && (r_starve != c_STARVE_MAX))
            r_starve <= r_starve + SW'(1);
    end

    sq_commit_sched_wb_fifo #(
        .WB_DEPTH   (WB_DEPTH)
    ) u_wb_fifo (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enq_cnt  (w_k),
        .i_enq_data (w_enq_data),
        .i_deq      (w_deq),
        .o_count    (w_count),
        .o_head     (w_head)
    );

    assign o_wb_count = w_count;
    assign o_wb_empty = (w_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_sq_commit_sched.sv
// ============================================================================
// Module      : tb_sq_commit_sched
// Description : Randomized and directed bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sq_commit_sched;
    import sq_commit_sched_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [2:0]           rob_st_retire;
    SQ_ENTRY_PACKET [2:0] sq_head_entries;
    logic [2:0]           retire;
    logic [2:0]           retire_stall;
    logic                 ld_req;
    logic [31:0]          ld_addr;
    logic                 ld_gnt;
    logic                 dc_valid;
    logic                 dc_wr;
    logic [31:0]          dc_addr;
    logic [31:0]          dc_data;
    logic [3:0]           dc_usebytes;
    logic                 dc_ready;
    logic [2:0]           wb_count;
    logic                 wb_empty;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } mstore_t;

    mstore_t q[$];
    int      starve = 0;

    always #5 clock = ~clock;

    sq_commit_sched #(
        .WB_DEPTH          (4),
        .DRAIN_THRESH      (3),
        .STARVE_MAX        (7)
    ) dut (
        .i_clock           (clock),
        .i_reset           (reset),
        .i_rob_st_retire   (rob_st_retire),
        .i_sq_head_entries (sq_head_entries),
        .o_retire          (retire),
        .o_retire_stall    (retire_stall),
        .i_ld_req          (ld_req),
        .i_ld_addr         (ld_addr),
        .o_ld_gnt          (ld_gnt),
        .o_dc_valid        (dc_valid),
        .o_dc_wr           (dc_wr),
        .o_dc_addr         (dc_addr),
        .o_dc_data         (dc_data),
        .o_dc_usebytes     (dc_usebytes),
        .i_dc_ready        (dc_ready),
        .o_wb_count        (wb_count),
        .o_wb_empty        (wb_empty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic SQ_ENTRY_PACKET mk(input logic [31:0] a, input logic [31:0] d,
                                          input logic [3:0] b, input logic r);
        SQ_ENTRY_PACKET e;
        e.ready = r; e.addr = a; e.data = d; e.usebytes = b;
        return e;
    endfunction

    function automatic SQ_ENTRY_PACKET rnd_entry();
        return mk($urandom, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 99) < 85);
    endfunction

    // Expected outputs come straight from the arbitration/acceptance rules
    // applied to the model queue, then the queue is advanced.
    task automatic model_check();
        int       cnt;
        bit       pri, deq, e_valid, e_wr, e_gnt;
        int       free, avail, k;
        logic [2:0] e_ret;
        cnt     = q.size();
        deq     = 0; e_valid = 0; e_wr = 0; e_gnt = 0;
        pri     = (cnt >= 3) || (starve == 7) || !ld_req;
        if (!reset) begin
            k = 0;
        end else begin
            if (cnt > 0 && pri) begin
                e_valid = 1; e_wr = 1; deq = dc_ready;
            end else if (ld_req) begin
                e_valid = 1; e_gnt = dc_ready;
            end
            free  = 4 - cnt + (deq ? 1 : 0);
            avail = 0;
            while (avail < 3 && rob_st_retire[avail] && sq_head_entries[avail].ready)
                avail++;
            k = (avail < free) ? avail : free;
        end
        e_ret = 3'((1 << k) - 1);

        chk("retire",       32'(retire),       32'(e_ret));
        chk("retire_stall", 32'(retire_stall), 32'(rob_st_retire & ~e_ret));
        chk("dc_valid",     32'(dc_valid),     32'(e_valid));
        chk("ld_gnt",       32'(ld_gnt),       32'(e_gnt));
        chk("wb_count",     32'(wb_count),     cnt);
        chk("wb_empty",     32'(wb_empty),     32'(cnt == 0));
        if (e_valid) begin
            chk("dc_wr", 32'(dc_wr), 32'(e_wr));
            if (e_wr) begin
                chk("dc_addr",     dc_addr,            q[0].a);
                chk("dc_data",     dc_data,            q[0].d);
                chk("dc_usebytes", 32'(dc_usebytes),   32'(q[0].b));
            end else begin
                chk("dc_addr_ld",  dc_addr,            ld_addr);
            end
        end

        if (!reset) begin
            q.delete();
            starve = 0;
        end else begin
            if (deq) begin
                void'(q.pop_front());
                starve = 0;
            end else if (cnt > 0 && starve < 7) begin
                starve++;
            end
            for (int i = 0; i < k; i++)
                q.push_back('{a: sq_head_entries[i].addr, d: sq_head_entries[i].data,
                              b: sq_head_entries[i].usebytes});
        end
    endtask

    task automatic step(input logic rst_n, input logic [2:0] rob, input SQ_ENTRY_PACKET [2:0] e,
                        input logic lreq, input logic [31:0] laddr, input logic rdy);
        @(posedge clock);
        #1;
        reset           = rst_n;
        rob_st_retire   = rst_n ? rob : 3'b000;
        sq_head_entries = e;
        ld_req          = lreq;
        ld_addr         = laddr;
        dc_ready        = rdy;
        @(negedge clock);
        model_check();
    endtask

    SQ_ENTRY_PACKET [2:0] ents;
    SQ_ENTRY_PACKET [2:0] none;

    task automatic idle(input int n, input logic lreq, input logic rdy);
        for (int i = 0; i < n; i++)
            step(1'b1, 3'b000, none, lreq, 32'h40, rdy);
    endtask

    initial begin
        reset = 1'b0; rob_st_retire = '0; sq_head_entries = '0;
        ld_req = 1'b0; ld_addr = '0; dc_ready = 1'b0;
        none = '0;
        for (int i = 0; i < 3; i++)
            ents[i] = mk(32'h100 + 32'(i * 4), 32'hd000_0000 + 32'(i), 4'hf, 1'b1);

        // Reset, then three stores retire together and drain in order.
        step(1'b0, 3'b000, none, 1'b0, 32'h0, 1'b0);
        step(1'b0, 3'b000, none, 1'b0, 32'h0, 1'b0);
        step(1'b1, 3'b111, ents, 1'b0, 32'h0, 1'b1);
        idle(4, 1'b0, 1'b1);

        // Threshold priority: three buffered stores beat a pending load.
        step(1'b1, 3'b111, ents, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++)
            step(1'b1, 3'b000, none, 1'b1, 32'hc0, 1'b1);
        idle(12, 1'b0, 1'b1);

        // Starvation: one store against a continuous load stream.
        step(1'b1, 3'b001, ents, 1'b1, 32'hc0, 1'b1);
        for (int i = 0; i < 10; i++)
            step(1'b1, 3'b000, none, 1'b1, 32'hc0, 1'b1);
        idle(3, 1'b0, 1'b1);

        // Full buffer accepts only the slot freed by a same-cycle dequeue.
        step(1'b1, 3'b111, ents, 1'b0, 32'h0, 1'b0);
        step(1'b1, 3'b001, ents, 1'b0, 32'h0, 1'b0);
        step(1'b1, 3'b011, ents, 1'b0, 32'h0, 1'b1);
        idle(6, 1'b0, 1'b1);

        // Non-ready middle entry truncates the prefix.
        ents[1].ready = 1'b0;
        step(1'b1, 3'b111, ents, 1'b0, 32'h0, 1'b0);
        ents[1].ready = 1'b1;
        idle(3, 1'b0, 1'b1);

        // Store held by dc_ready=0 must stay stable until accepted.
        ents[0] = mk(32'hbc, 32'h87ff_ffff, 4'hf, 1'b1);
        step(1'b1, 3'b001, ents, 1'b0, 32'h0, 1'b0);
        idle(3, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b1);

        // Random traffic with a reset dropped in mid-drain.
        for (int n = 0; n < 500; n++) begin
            SQ_ENTRY_PACKET [2:0] re;
            int nret;
            for (int i = 0; i < 3; i++) re[i] = rnd_entry();
            nret = $urandom_range(0, 3);
            step((n == 250) ? 1'b0 : 1'b1, 3'((1 << nret) - 1), re,
                 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sq_commit_sched.md
Name: sq_commit_sched

Overview:
- Sits between the ROB/SQ retire interface and the single D-cache port.
- Accepts up to 3 retiring stores per cycle from the SQ head into a small committed-store write buffer.
- Drains that buffer one store per cycle to the D-cache.
- Arbitrates the shared D-cache port between load requests and buffered store writes, with threshold- and starvation-based store priority.

Parameters:
- WB_DEPTH, 4, committed-store buffer entries (power of 2, ≥3)
- DRAIN_THRESH, 3, occupancy at or above which stores take port priority
- STARVE_MAX, 7, consecutive cycles a pending store may lose arbitration before forced priority

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rob_st_retire  in  3  stores the ROB wants to commit this cycle; bit0 = SQ head; bits contiguous from bit0
- sq_head_entries  in  3×SQ_ENTRY_PACKET  SQ entries at head, head+1, head+2
- retire  out  3  to SQ; pops this many head entries; always a contiguous prefix of rob_st_retire
- retire_stall  out  3  to ROB; rob_st_retire & ~retire
- ld_req  in  1  load requests D-cache port
- ld_addr  in  32  load address
- ld_gnt  out  1  load owns port this cycle
- dc_valid  out  1  D-cache command valid
- dc_wr  out  1  1 = store write, 0 = load read
- dc_addr  out  32  command address
- dc_data  out  32  store data
- dc_usebytes  out  4  store byte enables
- dc_ready  in  1  D-cache accepts command this cycle
- wb_count  out  $clog2(WB_DEPTH)+1  buffer occupancy (debug/display)
- wb_empty  out  1  buffer empty (fence/halt drain indicator)

Behaviour:
- Reset (reset==0 at posedge):
  - head, tail, count, starve counter all 0.
  - All outputs deasserted; wb_empty=1.
  - Reset mid-drain discards buffered stores.
- Acceptance (combinational):
  - free = WB_DEPTH − count + (store dequeued this cycle ? 1 : 0).
  - k = min(popcount(rob_st_retire), free); retire = lowest k bits set.
  - Entries are enqueued in order head→head+2 at posedge; tail advances by k modulo WB_DEPTH.
  - Only entries with ready==1 are accepted; a non-ready entry truncates the prefix at that position.
- Arbitration (combinational, each cycle):
  - store_pri = (count ≥ DRAIN_THRESH) | (starve == STARVE_MAX) | ~ld_req.
  - If count>0 & store_pri: store command.
    - dc_valid=1, dc_wr=1; addr/data/usebytes from buffer head; ld_gnt=0.
  - Else if ld_req: load command.
    - dc_valid=1, dc_wr=0, dc_addr=ld_addr; ld_gnt=dc_ready.
  - Else: dc_valid=0.
- Dequeue:
  - A store command with dc_ready=1 pops the buffer head at posedge.
  - With dc_ready=0, the same store is re-presented next cycle; no reordering.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle count>0 and a load wins or dc_ready=0.
  - Clears on any store dequeue.
- Simultaneous enqueue+dequeue: count_next = count + k − deq.
- Full buffer (count==WB_DEPTH): enqueue is allowed only up to the slot freed by a same-cycle dequeue.
- Pointer wrap: modulo WB_DEPTH.
- Buffered stores are never forwarded to loads. SQ forwarding covers only uncommitted stores, so the load path must not issue a load to an address overlapping a buffered store. That check belongs to the load unit, not this block.
- Latency: store enters the buffer at posedge N and may appear on dc_* during cycle N+1 at the earliest.

Decomposition:
- Shared package: SQ_ENTRY_PACKET (ready, addr, usebytes, data), the WB_ENTRY typedef (addr, data, usebytes), and the `LSQ define.
- One natural sub-module, wb_fifo: 3-in/1-out circular buffer exposing count and head entry.
- The arbiter and starvation logic stay in the top module.

Test Plan:
- Reset hold 2 cycles, then rob_st_retire=3'b111 with all 3 heads ready, ld_req=0, dc_ready=1 → retire=111; stores drain on dc_* in 3 consecutive cycles in order; wb_empty=1 after the 4th posedge.
- count=3 (DRAIN_THRESH), ld_req=1, ld_addr=32'hc0 → store wins: dc_wr=1, ld_gnt=0; load granted once count<3.
- count=1, ld_req held high for 10 cycles, dc_ready=1 → load wins 7 cycles; store is issued on cycle 8 (starve==7); counter clears.
- Buffer full (4), rob_st_retire=3'b011, dc_ready=1 with store issued → retire=001, retire_stall=010; count remains 4.
- rob_st_retire=3'b111 with sq_head_entries[1].ready=0 → retire=001, retire_stall=110.
- Store presented with dc_ready=0 for 3 cycles, addr 32'hbc/data 87ffffff/usebytes 1111 → dc_* outputs stable across all 3 cycles; popped on the first dc_ready=1.
